// File: rtl/train_sensor_filter_pkg.sv
// Shared definitions for the train sensor filter: per-channel debounce states
// and default timing constants.
package train_sensor_filter_pkg;

  localparam int DEB_CYCLES_DEFAULT     = 16;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    RISE_CHK = 2'b01,
    HIGH     = 2'b10,
    FALL_CHK = 2'b11
  } ch_state_t;

  // The filtered level only flips once a check state has confirmed the change.
  function automatic logic is_high_level(input ch_state_t s);
    return (s == HIGH) || (s == FALL_CHK);
  endfunction

endpackage

// File: rtl/train_sensor_filter_if.sv
// Sensor-side bundle of the train sensor filter: raw track sensors in,
// filtered levels, arrival pulses and stuck-sensor flag out.
interface train_sensor_filter_if;

  logic raw_v0;
  logic raw_v1;
  logic V0;
  logic V1;
  logic arr0;
  logic arr1;
  logic fault;

  modport master (
    output raw_v0, raw_v1,
    input  V0, V1, arr0, arr1, fault
  );

  modport slave (
    input  raw_v0, raw_v1,
    output V0, V1, arr0, arr1, fault
  );

endinterface

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: two-flop synchronizer, LOW/RISE_CHK/HIGH/FALL_CHK
// debounce FSM with its counter, and a registered arrival pulse.
module sensor_debounce_ch
  import train_sensor_filter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic arr
);

  localparam int            CW   = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          meta;
  logic          sync;
  ch_state_t     state;
  ch_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          arr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      state <= LOW;
      cnt   <= '0;
      arr   <= 1'b0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      arr   <= arr_nxt;
    end
  end

  // The arrival pulse is registered alongside the HIGH transition so it
  // lines up with the first cycle the filtered level reads 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    arr_nxt   = 1'b0;
    case (state)
      LOW: begin
        if (sync) begin
          state_nxt = RISE_CHK;
          cnt_nxt   = '0;
        end
      end
      RISE_CHK: begin
        if (!sync) begin
          state_nxt = LOW;
        end else if (cnt == LAST) begin
          state_nxt = HIGH;
          arr_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!sync) begin
          state_nxt = FALL_CHK;
          cnt_nxt   = '0;
        end
      end
      FALL_CHK: begin
        if (sync) begin
          state_nxt = HIGH;
        end else if (cnt == LAST) begin
          state_nxt = LOW;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = is_high_level(state);

endmodule

// File: rtl/train_sensor_filter.sv
// Two-channel train sensor filter. Optional stuck-sensor timeout enabled by
// defining SENSOR_FAULT_EN; without it fault reads 0 and no timer exists.
module train_sensor_filter
  import train_sensor_filter_pkg::*;
#(
  parameter int DEB_CYCLES     = DEB_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  train_sensor_filter_if.slave bus
);

  logic level0;
  logic level1;
  logic arr0_ch;
  logic arr1_ch;

  if (DEB_CYCLES < 2 || DEB_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("train_sensor_filter: DEB_CYCLES must be 2..255 and TIMEOUT_CYCLES >= 1");
  end

  sensor_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch0 (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.raw_v0),
    .level (level0),
    .arr   (arr0_ch)
  );

  sensor_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch1 (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.raw_v1),
    .level (level1),
    .arr   (arr1_ch)
  );

`ifdef SENSOR_FAULT_EN
  localparam int            TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo0;
  logic [TW-1:0] tmo1;
  logic          fault_q;

  // Each timer counts consecutive high cycles; the fault sets on the edge the
  // count would reach TIMEOUT_CYCLES and then holds until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo0    <= '0;
      tmo1    <= '0;
      fault_q <= 1'b0;
    end else begin
      if (level0) begin
        if (tmo0 == TLAST) fault_q <= 1'b1;
        else               tmo0    <= tmo0 + 1'b1;
      end else begin
        tmo0 <= '0;
      end
      if (level1) begin
        if (tmo1 == TLAST) fault_q <= 1'b1;
        else               tmo1    <= tmo1 + 1'b1;
      end else begin
        tmo1 <= '0;
      end
    end
  end

  // A stuck sensor forces both trains to read present so downstream stops.
  assign bus.fault = fault_q;
  assign bus.V0    = level0 | fault_q;
  assign bus.V1    = level1 | fault_q;
  assign bus.arr0  = arr0_ch & ~fault_q;
  assign bus.arr1  = arr1_ch & ~fault_q;
`else
  assign bus.fault = 1'b0;
  assign bus.V0    = level0;
  assign bus.V1    = level1;
  assign bus.arr0  = arr0_ch;
  assign bus.arr1  = arr1_ch;
`endif

endmodule

// File: doc/train_sensor_filter.md
TRAIN_SENSOR_FILTER -- requirements
Module: train_sensor_filter

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 16, number of consecutive stable synchronized samples required to accept a sensor level change (legal range 2..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, number of consecutive cycles a filtered sensor may stay high before a fault is declared.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 raw_v0  input  1  asynchronous, bouncy track sensor for train 0.
REQ-006 raw_v1  input  1  asynchronous, bouncy track sensor for train 1.
REQ-007 V0  output  1  filtered, registered sensor level for train 0; feeds the train-crossing FSM V0.
REQ-008 V1  output  1  filtered, registered sensor level for train 1; feeds the train-crossing FSM V1.
REQ-009 arr0  output  1  one-cycle pulse on each 0->1 transition of V0.
REQ-010 arr1  output  1  one-cycle pulse on each 0->1 transition of V1.
REQ-011 fault  output  1  sticky stuck-sensor flag; the port is present in every build.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 Each channel SHALL implement the FSM LOW, RISE_CHK, HIGH, FALL_CHK with a debounce counter sized for DEB_CYCLES-1.
REQ-014 LOW: sync=1 -> RISE_CHK with counter cleared to 0; otherwise remain.
REQ-015 RISE_CHK: sync=0 -> LOW; sync=1 with counter==DEB_CYCLES-1 -> HIGH; otherwise counter+1.
REQ-016 HIGH and FALL_CHK SHALL mirror LOW and RISE_CHK with the polarity inverted.
REQ-017 The filtered level SHALL be 1 in HIGH and FALL_CHK, and 0 in LOW and RISE_CHK.
REQ-018 Latency: for a raw level held stable from its first sampling edge (edge 0), the filtered output SHALL change on edge DEB_CYCLES+2.
REQ-019 Any reversal shorter than DEB_CYCLES synchronized samples SHALL leave the filtered output unchanged.
REQ-020 arr0 and arr1 SHALL assert in the same cycle V0 and V1 first read 1, for exactly one cycle.
REQ-021 The two channels SHALL be fully independent; simultaneous transitions on both channels SHALL produce simultaneous outputs.
REQ-022 No undefined states: any unused encoding SHALL return to LOW on the next edge.

Reset
REQ-023 While reset=1 at a clock edge, synchronizers, FSMs (LOW), counters and the fault flag SHALL clear, and V0, V1, arr0, arr1 and fault SHALL read 0 after that edge.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted after reset.

Configuration
REQ-025 Macro SENSOR_FAULT_EN: when defined, a per-channel timeout counter SHALL count cycles with the filtered level equal to 1.
REQ-026 With SENSOR_FAULT_EN defined, reaching TIMEOUT_CYCLES on either channel SHALL set fault=1, sticky until reset.
REQ-027 With SENSOR_FAULT_EN defined and fault=1, V0 and V1 SHALL both be forced to 1 (downstream all-stop, barrier down), and arr0 and arr1 SHALL be held at 0.
REQ-028 Without SENSOR_FAULT_EN, fault SHALL be tied to 0 and no timeout counter SHALL be synthesized.

Structure
REQ-029 A shared package SHALL hold the channel state encodings (LOW, RISE_CHK, HIGH, FALL_CHK) and the default DEB_CYCLES and TIMEOUT_CYCLES constants.
REQ-030 One sub-module, sensor_debounce_ch (synchronizer, FSM, counter, edge pulse), SHALL be instantiated twice; the top level SHALL hold only the fault logic and output muxing.

Verification (DEB_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-031 Reset: reset=1 for 2 cycles with raw inputs toggling -> all outputs 0 throughout and on the first edge after release.
REQ-032 Clean rise: raw_v0 held 1 from edge 0 -> V0=1 after edge 6, arr0=1 for that cycle only, V1 and arr1 remain 0.
REQ-033 Glitch: raw_v1 high for 3 cycles then low -> V1 and arr1 stay 0; a 1-cycle low glitch while V1=1 -> V1 stays 1.
REQ-034 Simultaneous: raw_v0 and raw_v1 rise on the same edge -> V0, V1, arr0 and arr1 assert on the same cycle (edge 6).
REQ-035 Reset mid-debounce: reset pulsed at edge 4 of a rise -> V0 stays 0; after release the rise requires a full 7 edges again.
REQ-036 Fault: raw_v0 held 1 for 40 cycles -> with SENSOR_FAULT_EN, fault=1 and V1 forced to 1 on the edge the timeout count reaches 20, persisting after raw_v0 drops; without SENSOR_FAULT_EN, fault=0 and V1=0.
